// File: rtl/mult_shift_add_if.sv
// Operand/result bundle shared by the multiplier and its arithmetic controller.
// The master drives the start request and operands; the slave returns product and status.
interface mult_shift_add_if #(
    parameter int WIDTH = 16
);
    logic               init_in;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2*WIDTH-1:0] pp;
    logic               busy;
    logic               done;

    modport master (
        output init_in, A, B,
        input  pp, busy, done
    );

    modport slave (
        input  init_in, A, B,
        output pp, busy, done
    );
endinterface

// File: rtl/mult_shift_add.sv
// Sequential unsigned shift-and-add multiplier; latency 1 + 2*(msb(B)+1) + popcount(B) cycles (1 if B=0).
// No backpressure: a start is taken only in IDLE/END, starts while busy are dropped.
module mult_shift_add #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    mult_shift_add_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        END   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] pp_q, pp_d;
    logic               init_q;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               start;

    assign start = bus.init_in & ~init_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        pp_d    = pp_q;
        case (state_q)
            IDLE, END: begin
                if (start) begin
                    a_d     = {{WIDTH{1'b0}}, bus.A};
                    b_d     = bus.B;
                    pp_d    = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (b_q == '0)
                    state_d = END;
                else if (b_q[0])
                    state_d = ADD;
                else
                    state_d = SHIFT;
            end
            ADD: begin
                pp_d    = pp_q + a_q;
                state_d = SHIFT;
            end
            SHIFT: begin
                a_d     = a_q << 1;
                b_d     = b_q >> 1;
                state_d = CHECK;
            end
            default: state_d = IDLE;
        endcase
        // Status flags are registered alongside the state so they stay pure Moore outputs.
        busy_d = (state_d == CHECK) || (state_d == ADD) || (state_d == SHIFT);
        done_d = (state_d == END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            pp_q    <= '0;
            init_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pp_q    <= pp_d;
            init_q  <= bus.init_in;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.pp   = pp_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
